// File: rtl/dmem_req_arbiter_pkg.sv
// Shared types for the DMem request arbiter: address width, grant index,
// FSM states and the latched access configuration.
package dmem_req_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;

    typedef logic [ADDR_WIDTH-1:0] address_t;
    typedef logic [1:0]            gidx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef struct packed {
        address_t length;
        address_t stride;
        address_t base;
    } acc_cfg_t;

    // Next requester index modulo 3.
    function automatic gidx_t gidx_inc(gidx_t i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/dmem_req_arbiter_pick.sv
// rr_pick3: combinational round-robin picker over three requesters.
// Search starts at ptr and proceeds ascending modulo 3; the first set
// request wins. A pointer of 3 is treated as 0.
module rr_pick3
    import dmem_req_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  gidx_t      ptr,
    output logic       vld,
    output gidx_t      idx
);

    gidx_t      ptr_n;
    logic [2:0] cand;

    assign ptr_n = (ptr == 2'd3) ? 2'd0 : ptr;

    // Walk the search order backwards so the nearest candidate overwrites last.
    always_comb begin
        vld  = 1'b0;
        idx  = 2'd0;
        cand = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_n} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (req[cand[1:0]]) begin
                vld = 1'b1;
                idx = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_req_arbiter.sv
// dmem_req_arbiter: grants one DMem AGU port to one of three requesters.
// Round-robin pick in IDLE, config latched on the IDLE->GRANT edge, grant
// held until I_Term, then one RELEASE cycle with all grants low.
module dmem_req_arbiter
    import dmem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int NUM_REQ = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Req1,
    input  logic              I_Req2,
    input  logic              I_Req3,
    input  logic [ADDR_W-1:0] I_Length1,
    input  logic [ADDR_W-1:0] I_Length2,
    input  logic [ADDR_W-1:0] I_Length3,
    input  logic [ADDR_W-1:0] I_Stride1,
    input  logic [ADDR_W-1:0] I_Stride2,
    input  logic [ADDR_W-1:0] I_Stride3,
    input  logic [ADDR_W-1:0] I_Base_Addr1,
    input  logic [ADDR_W-1:0] I_Base_Addr2,
    input  logic [ADDR_W-1:0] I_Base_Addr3,
    input  logic              I_Term,
    output logic              O_Grant1,
    output logic              O_Grant2,
    output logic              O_Grant3,
    output logic              O_GrantVld,
    output logic [1:0]        O_GrantNo,
    output logic [ADDR_W-1:0] O_Length,
    output logic [ADDR_W-1:0] O_Stride,
    output logic [ADDR_W-1:0] O_Base_Addr,
    output logic              O_Start,
    output logic              O_Busy
);

    if (NUM_REQ != 3) begin : g_bad_num_req
        $error("dmem_req_arbiter: NUM_REQ must be 3");
    end
    if (ADDR_W != ADDR_WIDTH) begin : g_bad_addr_w
        $error("dmem_req_arbiter: ADDR_W must match address_t width");
    end

    arb_state_e state_q, state_n;
    logic [2:0] grant_q, grant_d;
    logic       gvld_q;
    gidx_t      gno_q, gno_d;
    gidx_t      ptr_q, ptr_d;
    acc_cfg_t   cfg_q, cfg_d, cfg_sel;
    logic       start_q, start_d;
    logic       busy_q;
    logic       pick_vld;
    gidx_t      pick_idx;
    logic [2:0] req_vec;

    assign req_vec = {I_Req3, I_Req2, I_Req1};

    rr_pick3 u_pick (
        .req (req_vec),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Config of the current round-robin winner.
    always_comb begin
        case (pick_idx)
            2'd1:    cfg_sel = '{I_Length2, I_Stride2, I_Base_Addr2};
            2'd2:    cfg_sel = '{I_Length3, I_Stride3, I_Base_Addr3};
            default: cfg_sel = '{I_Length1, I_Stride1, I_Base_Addr1};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next state: arbitrate only in IDLE; only I_Term ends a grant.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_n = GRANT;
            GRANT:   if (I_Term)   state_n = RELEASE;
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output next values: latch winner on grant, clear and advance pointer on term.
    always_comb begin
        grant_d = grant_q;
        gno_d   = gno_q;
        cfg_d   = cfg_q;
        ptr_d   = ptr_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = 3'b001 << pick_idx;
                    gno_d   = pick_idx;
                    cfg_d   = cfg_sel;
                    start_d = 1'b1;
                end
            end
            GRANT: begin
                if (I_Term) begin
                    grant_d = 3'b000;
                    gno_d   = 2'd0;
                    ptr_d   = gidx_inc(gno_q);
                end
            end
            default: ;
        endcase
    end

    // Output registers; every port is driven straight from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_q <= 3'b000;
            gvld_q  <= 1'b0;
            gno_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cfg_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            grant_q <= grant_d;
            gvld_q  <= |grant_d;
            gno_q   <= gno_d;
            ptr_q   <= ptr_d;
            cfg_q   <= cfg_d;
            start_q <= start_d;
            busy_q  <= (state_n != IDLE);
        end
    end

    assign O_Grant1    = grant_q[0];
    assign O_Grant2    = grant_q[1];
    assign O_Grant3    = grant_q[2];
    assign O_GrantVld  = gvld_q;
    assign O_GrantNo   = gno_q;
    assign O_Length    = cfg_q.length;
    assign O_Stride    = cfg_q.stride;
    assign O_Base_Addr = cfg_q.base;
    assign O_Start     = start_q;
    assign O_Busy      = busy_q;

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Bench for dmem_req_arbiter: directed scenarios plus random req/term traffic,
// all compared against a transaction-level reference model.
module tb_dmem_req_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic        term  = 1'b0;
    logic [15:0] cfg_len  [3];
    logic [15:0] cfg_str  [3];
    logic [15:0] cfg_base [3];

    logic        O_Grant1, O_Grant2, O_Grant3, O_GrantVld, O_Start, O_Busy;
    logic [1:0]  O_GrantNo;
    logic [15:0] O_Length, O_Stride, O_Base_Addr;
    logic [2:0]  gnt;
    assign gnt = {O_Grant3, O_Grant2, O_Grant1};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    dmem_req_arbiter #(.ADDR_W(16), .NUM_REQ(3)) dut (
        .clock(clock), .reset(reset),
        .I_Req1(req[0]), .I_Req2(req[1]), .I_Req3(req[2]),
        .I_Length1(cfg_len[0]), .I_Length2(cfg_len[1]), .I_Length3(cfg_len[2]),
        .I_Stride1(cfg_str[0]), .I_Stride2(cfg_str[1]), .I_Stride3(cfg_str[2]),
        .I_Base_Addr1(cfg_base[0]), .I_Base_Addr2(cfg_base[1]), .I_Base_Addr3(cfg_base[2]),
        .I_Term(term),
        .O_Grant1(O_Grant1), .O_Grant2(O_Grant2), .O_Grant3(O_Grant3),
        .O_GrantVld(O_GrantVld), .O_GrantNo(O_GrantNo),
        .O_Length(O_Length), .O_Stride(O_Stride), .O_Base_Addr(O_Base_Addr),
        .O_Start(O_Start), .O_Busy(O_Busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: owner index (-1 idle), cool-down cycles before the
    // next arbitration, round-robin start point, latched config.
    int          m_own = -1;
    int          m_cool = 0;
    int          m_ptr = 0;
    logic        m_start = 1'b0;
    logic [15:0] m_len = '0, m_str = '0, m_base = '0;

    function automatic int rr_ref(logic [2:0] r, int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_own <= -1; m_cool <= 0; m_ptr <= 0; m_start <= 1'b0;
            m_len <= '0; m_str <= '0; m_base <= '0;
        end else begin
            m_start <= 1'b0;
            if (m_own >= 0) begin
                if (term) begin
                    m_ptr  <= (m_own + 1) % 3;
                    m_own  <= -1;
                    m_cool <= 1;
                end
            end else if (m_cool > 0) begin
                m_cool <= m_cool - 1;
            end else if (rr_ref(req, m_ptr) >= 0) begin
                m_own   <= rr_ref(req, m_ptr);
                m_start <= 1'b1;
                m_len   <= cfg_len[rr_ref(req, m_ptr)];
                m_str   <= cfg_str[rr_ref(req, m_ptr)];
                m_base  <= cfg_base[rr_ref(req, m_ptr)];
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus invariants.
    always @(negedge clock) begin
        if (reset) begin
            chk("gnt",    {29'd0, gnt}, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
            chk("gvld",   {31'd0, O_GrantVld}, {31'd0, m_own >= 0});
            chk("gno",    {30'd0, O_GrantNo}, (m_own >= 0) ? m_own : 0);
            chk("start",  {31'd0, O_Start}, {31'd0, m_start});
            chk("busy",   {31'd0, O_Busy}, {31'd0, (m_own >= 0) || (m_cool > 0)});
            chk("len",    {16'd0, O_Length}, {16'd0, m_len});
            chk("stride", {16'd0, O_Stride}, {16'd0, m_str});
            chk("base",   {16'd0, O_Base_Addr}, {16'd0, m_base});
            chk("onehot0",  {31'd0, $onehot0(gnt)}, 32'd1);
            chk("gno_ne3",  {31'd0, O_GrantNo != 2'd3}, 32'd1);
            chk("start_vld", {31'd0, !O_Start || O_GrantVld}, 32'd1);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0; req = 3'b000; term = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    // Wait (bounded) for an O_Start; w = granted index, n = negedges waited.
    task automatic wait_start(output int w, output int n);
        w = -1; n = 0;
        while (n < 20) begin
            tick(); n++;
            if (O_Start) begin
                w = O_Grant1 ? 0 : O_Grant2 ? 1 : O_Grant3 ? 2 : -1;
                break;
            end
        end
        if (n >= 20 && w < 0) chk("start_timeout", 32'd0, 32'd1);
    endtask

    int w, n;
    int waitc [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            cfg_len[i] = 16'd0; cfg_str[i] = 16'd0; cfg_base[i] = 16'd0;
        end

        // Reset state and a single requester.
        apply_reset();
        chk("rst_gnt",  {29'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, O_Busy}, 32'd0);
        cfg_len[0] = 16'd8; cfg_str[0] = 16'd1; cfg_base[0] = 16'h0040;
        req[0] = 1'b1;
        tick();
        chk("t1_grant1", {31'd0, O_Grant1}, 32'd1);
        chk("t1_gno",    {30'd0, O_GrantNo}, 32'd0);
        chk("t1_start",  {31'd0, O_Start}, 32'd1);
        chk("t1_len",    {16'd0, O_Length}, 32'd8);
        chk("t1_base",   {16'd0, O_Base_Addr}, 32'h40);
        req[0] = 1'b0;
        tick();
        chk("t1_start_drop", {31'd0, O_Start}, 32'd0);
        repeat (6) tick();
        term = 1'b1; tick(); term = 1'b0;
        chk("t1_rel_gnt",  {29'd0, gnt}, 32'd0);
        chk("t1_rel_busy", {31'd0, O_Busy}, 32'd1);
        tick();
        chk("t1_idle_busy", {31'd0, O_Busy}, 32'd0);

        // All three held: order 1,2,3,1,2,3 with a 2-cycle gap.
        apply_reset();
        cfg_len[1] = 16'd3; cfg_len[2] = 16'd5;
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            wait_start(w, n);
            chk("t2_order", w, g % 3);
            if (g > 0) chk("t2_gap", n, 32'd2);
            tick(); tick();
            term = 1'b1; tick(); term = 1'b0;
        end
        req = 3'b000;

        // Request drop and config change mid-access are ignored.
        apply_reset();
        cfg_base[0] = 16'h0040; req[0] = 1'b1;
        wait_start(w, n);
        cfg_base[0] = 16'h0100; req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_base_held", {16'd0, O_Base_Addr}, 32'h40);
            chk("t3_gnt_held",  {31'd0, O_Grant1}, 32'd1);
        end
        term = 1'b1; tick(); term = 1'b0;
        chk("t3_released", {29'd0, gnt}, 32'd0);

        // I_Term during the O_Start cycle, then I_Term while idle.
        apply_reset();
        req[1] = 1'b1;
        wait_start(w, n);
        chk("t4_win", w, 32'd1);
        term = 1'b1; req[1] = 1'b0; tick(); term = 1'b0;
        chk("t4_term_on_start", {29'd0, gnt}, 32'd0);
        tick(); tick();
        term = 1'b1; tick(); term = 1'b0;
        chk("t4_idle_term_gnt",  {29'd0, gnt}, 32'd0);
        tick();
        chk("t4_idle_term_busy", {31'd0, O_Busy}, 32'd0);

        // Asynchronous reset mid-grant; pointer returns to requester 1 first.
        apply_reset();
        req[2] = 1'b1;
        wait_start(w, n);
        chk("t5_win3", w, 32'd2);
        tick();
        @(posedge clock); #3 reset = 1'b0; #1;
        chk("t5_arst_gnt",   {29'd0, gnt}, 32'd0);
        chk("t5_arst_vld",   {31'd0, O_GrantVld}, 32'd0);
        chk("t5_arst_start", {31'd0, O_Start}, 32'd0);
        chk("t5_arst_busy",  {31'd0, O_Busy}, 32'd0);
        chk("t5_arst_len",   {16'd0, O_Length}, 32'd0);
        req = 3'b110;
        tick();
        #2 reset = 1'b1;
        wait_start(w, n);
        chk("t5_after_rst", w, 32'd1);
        term = 1'b1; tick(); term = 1'b0; req = 3'b000;

        // Random traffic with a starvation bound.
        apply_reset();
        for (int i = 0; i < 3; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (O_Start) begin
                w = O_Grant1 ? 0 : O_Grant2 ? 1 : 2;
                chk("starve", {31'd0, waitc[w] <= 2}, 32'd1);
                waitc[w] = 0;
                for (int i = 0; i < 3; i++)
                    if (i != w && req[i]) waitc[i]++;
            end
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i]      = 1'b1;
                        cfg_len[i]  = 16'($urandom);
                        cfg_str[i]  = 16'($urandom);
                        cfg_base[i] = 16'($urandom);
                    end
                end else if (gnt[i] && $urandom_range(0, 1) == 0) begin
                    req[i] = 1'b0;
                end
            end
            term = (gnt != 3'b000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        end
        term = 1'b0; req = 3'b000;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_req_arbiter.md
Name: dmem_req_arbiter

Overview:
- Grants exclusive use of one DMem access port (store or load AGU) to one of three requesters: lane 1, lane 2 and the external router handler (requester 3).
- Round-robin arbitration between the three.
- Latches the winner's length/stride/base and holds the grant until the AGU signals end of access.
- Issues a one-cycle configuration-start pulse to the AGU.
- DMem instantiates two copies: store side and load side.

Parameters:
- ADDR_W, 16, width of address_t (length, stride, base); must equal pkg_tpu address_t width.
- NUM_REQ, 3, number of requesters; fixed at 3 in this revision, elaborates an error otherwise.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- I_Req1/I_Req2/I_Req3  in  1 each  access request, level, held until granted.
- I_Length1..3  in  ADDR_W each  access length (element count) per requester.
- I_Stride1..3  in  ADDR_W each  stride per requester.
- I_Base_Addr1..3  in  ADDR_W each  base address per requester.
- I_Term  in  1  end-of-access from AGU (End_Access).
- O_Grant1/O_Grant2/O_Grant3  out  1 each  grant, one-hot or all zero.
- O_GrantVld  out  1  OR of the grants.
- O_GrantNo  out  2  index of the granted requester (0, 1 or 2); 0 when idle.
- O_Length/O_Stride/O_Base_Addr  out  ADDR_W each  latched config of the winner.
- O_Start  out  1  one-cycle pulse: load config into AGU.
- O_Busy  out  1  high in GRANT and RELEASE states.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all grants 0, O_GrantVld 0, O_GrantNo 0, O_Length/O_Stride/O_Base_Addr 0, O_Start 0, O_Busy 0, RR pointer 0.
- Reset asserted mid-access: immediate abort to the reset state; no O_Start or extra grant is produced on release of reset.
- All outputs are registered.
- FSM IDLE:
  - If any I_Req is high, select the winner by round-robin: search order starts at the RR pointer, then ascending modulo 3.
  - On the next edge: latch the winner's length/stride/base, set its grant, O_GrantNo = index, O_Start = 1, go to GRANT.
  - Request-to-grant latency is 1 cycle.
- FSM GRANT:
  - Grant and config are held constant; O_Start drops after its first cycle.
  - Changes on I_Req* and requester config inputs are ignored. A requester dropping its request does not release the grant; only I_Term releases it.
  - On I_Term=1 (sampled in any GRANT cycle, including the O_Start cycle): go to RELEASE, clear grants and O_GrantVld, set RR pointer = (winner+1) mod 3.
- FSM RELEASE:
  - Exactly one cycle with all grants 0, so the AGU and pub-domain logic see a clean gap.
  - Then IDLE. New arbitration is evaluated in IDLE, so the minimum gap between grants is 2 cycles after I_Term.
- I_Term in IDLE or RELEASE is ignored.
- Simultaneous requests: winner is determined by RR order only. After reset the priority is 1 > 2 > 3.
- Fairness: any continuously asserted request is granted within 2 other grants.
- Config inputs are sampled only on the IDLE→GRANT edge. Length 0 is passed through unchanged; the AGU handles it.
- O_GrantNo is 2 bits; value 3 never occurs (assertion in bench).
- Invariants:
  - $onehot0 of the grants at all times.
  - O_GrantVld == |grants.
  - O_Start implies O_GrantVld.

Decomposition:
- pkg_tpu provides: address_t, a grant-index typedef (2-bit), and an enum for FSM states IDLE/GRANT/RELEASE.
- One natural sub-module: rr_pick3. Combinational round-robin picker taking the req vector and pointer, returning a valid flag and a 2-bit index. It is reusable by the router.
- Config latch and FSM stay in the top module.

Test Plan:
- Reset then I_Req1=1 alone with Length=8, Stride=1, Base=0x0040 → next cycle O_Grant1=1, O_GrantNo=0, O_Start pulse of 1 cycle, O_Length=8, O_Base_Addr=0x0040; I_Term after 8 cycles → grant low for 1 RELEASE cycle, O_Busy low the following cycle.
- All three requests held continuously, I_Term issued 3 cycles after each grant → grant order 1,2,3,1,2,3; gap of 2 cycles with grants 0 between grants.
- Requester 1 granted, then I_Base_Addr1 changes to 0x0100 and I_Req1 drops mid-access → O_Base_Addr stays at the latched 0x0040, grant held until I_Term.
- I_Term asserted in the same cycle as O_Start → transition to RELEASE next edge; I_Term pulse while IDLE → no state change, no grant.
- reset driven low asynchronously (between clock edges) during GRANT with requester 3 active → all outputs 0 immediately; after reset release with I_Req2=1, I_Req3=1 → requester 2 wins (pointer reset to 0).
- Random req/term stimulus for 10k cycles → onehot0 grants, GrantNo never 3, no request starved longer than 2 grants.
